// File: rtl/pc_sequencer.sv
// Program counter and condition-flag register for the GCD datapath processor.
// Turns the controller's next-PC select code into a registered fetch address, with fault and debug status.
module pc_sequencer #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         sel,
    input  logic [ADDR_W-1:0]  branch_addr,
    input  logic               stall,
    input  logic               flag_we,
    input  logic               alu_zero,
    input  logic               alu_neg,
    output logic [ADDR_W-1:0]  pc,
    output logic               pc_valid,
    output logic               zero_flag,
    output logic               neg_flag,
    output logic               pc_wrap,
    output logic               fault,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [3:0] SEL_INC   = 4'd0;
    localparam logic [3:0] SEL_HOLD  = 4'd1;
    localparam logic [3:0] SEL_LOAD  = 4'd2;
    localparam logic [3:0] SEL_SRST  = 4'd3;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               valid_q, valid_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               wrap_q, wrap_d;
    logic               fault_q, fault_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0] cnt_sat;
    logic               soft_rst;

    // Retired count sticks at all-ones instead of wrapping.
    assign cnt_sat = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        wrap_d   = 1'b0;
        fault_d  = fault_q;
        cnt_d    = cnt_q;
        soft_rst = 1'b0;

        if (state_q != BOOT && flag_we) begin
            zero_d = alu_zero;
            neg_d  = alu_neg;
        end

        case (state_q)
            BOOT: begin
                state_d = RUN;
                valid_d = 1'b1;
            end
            RUN: begin
                if (!stall) begin
                    case (sel)
                        SEL_INC: begin
                            pc_d   = pc_q + 1'b1;
                            wrap_d = (pc_q == '1);
                            cnt_d  = cnt_sat;
                        end
                        SEL_HOLD: ;
                        SEL_LOAD: begin
                            pc_d  = branch_addr;
                            cnt_d = cnt_sat;
                        end
                        SEL_SRST: soft_rst = 1'b1;
                        default: begin
                            fault_d = 1'b1;
                            valid_d = 1'b0;
                            state_d = FAULT;
                        end
                    endcase
                end
            end
            FAULT: begin
                if (!stall && sel == SEL_SRST) begin
                    soft_rst = 1'b1;
                    fault_d  = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = RUN;
                end
            end
            default: state_d = BOOT;
        endcase

        // Soft reset overrides any flag write issued in the same cycle.
        if (soft_rst) begin
            pc_d   = RESET_VEC;
            cnt_d  = '0;
            zero_d = 1'b1;
            neg_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            zero_q  <= 1'b1;
            neg_q   <= 1'b0;
            wrap_q  <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            wrap_q  <= wrap_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign pc_valid    = valid_q;
    assign zero_flag   = zero_q;
    assign neg_flag    = neg_q;
    assign pc_wrap     = wrap_q;
    assign fault       = fault_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table of hand-computed results plus
// hand-written sequences for counter saturation and mid-run hard reset.
module tb_pc_sequencer;

    localparam int ADDR_W  = 8;
    localparam int COUNT_W = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         sel;
    logic [ADDR_W-1:0]  branch_addr;
    logic               stall;
    logic               flag_we;
    logic               alu_zero;
    logic               alu_neg;
    logic [ADDR_W-1:0]  pc;
    logic               pc_valid;
    logic               zero_flag;
    logic               neg_flag;
    logic               pc_wrap;
    logic               fault;
    logic [COUNT_W-1:0] instr_count;

    pc_sequencer #(
        .ADDR_W    (ADDR_W),
        .RESET_VEC (8'h00),
        .COUNT_W   (COUNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel         (sel),
        .branch_addr (branch_addr),
        .stall       (stall),
        .flag_we     (flag_we),
        .alu_zero    (alu_zero),
        .alu_neg     (alu_neg),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .zero_flag   (zero_flag),
        .neg_flag    (neg_flag),
        .pc_wrap     (pc_wrap),
        .fault       (fault),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic              rst_n;
        logic [3:0]        sel;
        logic [7:0]        ba;
        logic              stall;
        logic              fwe;
        logic              az;
        logic              an;
        logic [7:0]        e_pc;
        logic              e_valid;
        logic              e_zero;
        logic              e_neg;
        logic              e_wrap;
        logic              e_fault;
        logic [3:0]        e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(string name, logic r, logic [3:0] s, logic [7:0] ba,
                                logic st, logic fwe, logic az, logic an,
                                logic [7:0] pc_e, logic v_e, logic z_e, logic n_e,
                                logic w_e, logic f_e, logic [3:0] c_e);
        vec_t t;
        t.name = name; t.rst_n = r; t.sel = s; t.ba = ba; t.stall = st;
        t.fwe = fwe; t.az = az; t.an = an;
        t.e_pc = pc_e; t.e_valid = v_e; t.e_zero = z_e; t.e_neg = n_e;
        t.e_wrap = w_e; t.e_fault = f_e; t.e_cnt = c_e;
        return t;
    endfunction

    task automatic drive(logic r, logic [3:0] s, logic [7:0] ba, logic st,
                         logic fwe, logic az, logic an);
        rst_n = r; sel = s; branch_addr = ba; stall = st;
        flag_we = fwe; alu_zero = az; alu_neg = an;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [7:0] pc_e, logic v_e, logic z_e,
                         logic n_e, logic w_e, logic f_e, logic [3:0] c_e);
        logic [16:0] act, exp;
        act = {pc, pc_valid, zero_flag, neg_flag, pc_wrap, fault, instr_count};
        exp = {pc_e, v_e, z_e, n_e, w_e, f_e, c_e};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got pc=%h valid=%b z=%b n=%b wrap=%b fault=%b cnt=%0d, want pc=%h valid=%b z=%b n=%b wrap=%b fault=%b cnt=%0d",
                     name, pc, pc_valid, zero_flag, neg_flag, pc_wrap, fault, instr_count,
                     pc_e, v_e, z_e, n_e, w_e, f_e, c_e);
        end
    endtask

    initial begin
        rst_n = 1'b0; sel = 4'd0; branch_addr = 8'h00; stall = 1'b0;
        flag_we = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0;

        //                 name          rst sel ba     st fwe az an   pc     v z n w f cnt
        vecs.push_back(mk("reset",       0, 0, 8'h00, 0, 0, 0, 0,  8'h00, 0,1,0,0,0, 0));
        vecs.push_back(mk("boot_ignore", 1, 2, 8'h55, 0, 1, 0, 1,  8'h00, 1,1,0,0,0, 0));
        vecs.push_back(mk("inc_1",       1, 0, 8'h00, 0, 0, 0, 0,  8'h01, 1,1,0,0,0, 1));
        vecs.push_back(mk("inc_2",       1, 0, 8'h00, 0, 0, 0, 0,  8'h02, 1,1,0,0,0, 2));
        vecs.push_back(mk("inc_3",       1, 0, 8'h00, 0, 0, 0, 0,  8'h03, 1,1,0,0,0, 3));
        vecs.push_back(mk("inc_4",       1, 0, 8'h00, 0, 0, 0, 0,  8'h04, 1,1,0,0,0, 4));
        vecs.push_back(mk("load_20",     1, 2, 8'h20, 0, 0, 0, 0,  8'h20, 1,1,0,0,0, 5));
        vecs.push_back(mk("load_7a",     1, 2, 8'h7A, 0, 0, 0, 0,  8'h7A, 1,1,0,0,0, 6));
        vecs.push_back(mk("hold_1",      1, 1, 8'h11, 0, 0, 0, 0,  8'h7A, 1,1,0,0,0, 6));
        vecs.push_back(mk("hold_2",      1, 1, 8'h22, 0, 0, 0, 0,  8'h7A, 1,1,0,0,0, 6));
        vecs.push_back(mk("hold_3",      1, 1, 8'h33, 0, 0, 0, 0,  8'h7A, 1,1,0,0,0, 6));
        vecs.push_back(mk("load_ff",     1, 2, 8'hFF, 0, 0, 0, 0,  8'hFF, 1,1,0,0,0, 7));
        vecs.push_back(mk("stall_wrap",  1, 0, 8'h00, 1, 0, 0, 0,  8'hFF, 1,1,0,0,0, 7));
        vecs.push_back(mk("wrap",        1, 0, 8'h00, 0, 0, 0, 0,  8'h00, 1,1,0,1,0, 8));
        vecs.push_back(mk("wrap_clear",  1, 1, 8'h00, 0, 0, 0, 0,  8'h00, 1,1,0,0,0, 8));
        vecs.push_back(mk("load_44",     1, 2, 8'h44, 0, 0, 0, 0,  8'h44, 1,1,0,0,0, 9));
        vecs.push_back(mk("stall_flags", 1, 2, 8'h33, 1, 1, 0, 1,  8'h44, 1,0,1,0,0, 9));
        vecs.push_back(mk("stall_illeg", 1, 7, 8'h00, 1, 0, 0, 0,  8'h44, 1,0,1,0,0, 9));
        vecs.push_back(mk("srst_flags",  1, 3, 8'h00, 0, 1, 0, 1,  8'h00, 1,1,0,0,0, 0));
        vecs.push_back(mk("load_10",     1, 2, 8'h10, 0, 0, 0, 0,  8'h10, 1,1,0,0,0, 1));
        vecs.push_back(mk("illegal_4",   1, 4, 8'h00, 0, 0, 0, 0,  8'h10, 0,1,0,0,1, 1));
        vecs.push_back(mk("fault_inc",   1, 0, 8'h00, 0, 0, 0, 0,  8'h10, 0,1,0,0,1, 1));
        vecs.push_back(mk("fault_load",  1, 2, 8'h55, 0, 0, 0, 0,  8'h10, 0,1,0,0,1, 1));
        vecs.push_back(mk("fault_flags", 1, 1, 8'h00, 0, 1, 0, 0,  8'h10, 0,0,0,0,1, 1));
        vecs.push_back(mk("fault_stall", 1, 3, 8'h00, 1, 0, 0, 0,  8'h10, 0,0,0,0,1, 1));
        vecs.push_back(mk("fault_exit",  1, 3, 8'h00, 0, 0, 0, 0,  8'h00, 1,1,0,0,0, 0));
        vecs.push_back(mk("illegal_15",  1, 15, 8'h00, 0, 0, 0, 0, 8'h00, 0,1,0,0,1, 0));
        vecs.push_back(mk("fault_exit2", 1, 3, 8'h00, 0, 0, 0, 0,  8'h00, 1,1,0,0,0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].sel, vecs[i].ba, vecs[i].stall,
                  vecs[i].fwe, vecs[i].az, vecs[i].an);
            check(vecs[i].name, vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_zero,
                  vecs[i].e_neg, vecs[i].e_wrap, vecs[i].e_fault, vecs[i].e_cnt);
        end

        // Twenty increments from pc=0, cnt=0: count must stop at 15.
        for (int k = 1; k <= 20; k++) begin
            logic [7:0] pc_e;
            logic [3:0] c_e;
            pc_e = 8'(k);
            c_e  = (k > 15) ? 4'd15 : 4'(k);
            drive(1, 0, 8'h00, 0, 0, 0, 0);
            check($sformatf("sat_%0d", k), pc_e, 1, 1, 0, 0, 0, c_e);
        end

        // Hard reset mid-run beats a simultaneous branch; BOOT then ignores sel.
        drive(0, 2, 8'h99, 0, 1, 0, 1);
        check("hard_rst", 8'h00, 0, 1, 0, 0, 0, 0);
        drive(1, 2, 8'h99, 0, 0, 0, 0);
        check("post_boot", 8'h00, 1, 1, 0, 0, 0, 0);
        drive(1, 2, 8'h99, 0, 0, 0, 0);
        check("first_run", 8'h99, 1, 1, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
